// File: rtl/seg7_digit_scanner_pkg.sv
// Shared constants for the 7-segment digit scanner.
// Segment bit 0 is segment a, bit 6 is segment g.
package seg7_digit_scanner_pkg;

    localparam int DEFAULT_NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic is_bcd(input logic [3:0] v);
        return v <= 4'd9;
    endfunction

endpackage

// File: rtl/seg7_digit_scanner_decoder.sv
// BCD to 7-segment decoder; non-BCD codes decode to blank.
// Purely combinational, shared by all digit slots.
module seg7_digit_scanner_decoder
    import seg7_digit_scanner_pkg::*;
(
    input  logic [3:0] counter,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (counter)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_digit_scanner.sv
// Multiplexed 7-segment scanner with blank gap, PWM dimming,
// leading-zero blanking and a frame-aligned double buffer.
module seg7_digit_scanner
    import seg7_digit_scanner_pkg::*;
#(
    parameter int          NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter logic [15:0] SLOT_CYCLES  = 16'd10000,
    parameter logic [15:0] BLANK_CYCLES = 16'd100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      digits_valid,
    output logic                      digits_ready,
    input  logic [3:0]                brightness,
    input  logic                      lz_blank,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     dig_en,
    output logic                      frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [15:0]   SLOT_LAST = SLOT_CYCLES - 16'd1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [15:0]                  slot_cnt;
    logic [IW-1:0]                scan_idx;
    logic [NUM_DIGITS-1:0][3:0]   active_buf;
    logic [NUM_DIGITS-1:0][3:0]   shadow_buf;
    logic [NUM_DIGITS-1:0]        active_dp;
    logic [NUM_DIGITS-1:0]        shadow_dp;
    logic                         shadow_full;

    logic                         slot_end;
    logic                         swap_point;
    logic                         accept;
    logic [3:0]                   cur_digit;
    logic                         cur_dp;
    logic [6:0]                   dec_seg;
    logic [NUM_DIGITS-1:0]        lz_mask;
    logic                         zero_run;
    logic                         lit;
    logic                         blank_digit;
    logic [6:0]                   seg_next;
    logic [NUM_DIGITS-1:0]        dig_next;

    assign slot_end     = (slot_cnt == SLOT_LAST);
    assign swap_point   = slot_end && (scan_idx == IDX_LAST);
    assign digits_ready = !shadow_full;
    assign accept       = digits_valid && !shadow_full;

    // Slot and digit scan counters
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            scan_idx <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 16'd1;
        end
    end

    // Shadow fills on handshake; active is only replaced at the frame swap
    always_ff @(posedge clk) begin
        if (reset) begin
            active_buf  <= '0;
            active_dp   <= '0;
            shadow_buf  <= '0;
            shadow_dp   <= '0;
            shadow_full <= 1'b0;
        end else begin
            if (swap_point && shadow_full) begin
                active_buf  <= shadow_buf;
                active_dp   <= shadow_dp;
                shadow_full <= 1'b0;
            end
            if (accept) begin
                shadow_buf  <= digits_in;
                shadow_dp   <= dp_in;
                shadow_full <= 1'b1;
            end
        end
    end

    assign cur_digit = active_buf[scan_idx];
    assign cur_dp    = active_dp[scan_idx];

    seg7_digit_scanner_decoder u_dec (
        .counter  (cur_digit),
        .segments (dec_seg)
    );

    // A digit is leading-zero if it and every digit above it is zero
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run && (active_buf[i] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    assign blank_digit = !is_bcd(cur_digit) ||
                         (lz_blank && lz_mask[scan_idx]);

    assign lit = (slot_cnt >= BLANK_CYCLES) &&
                 (brightness == 4'hF || slot_cnt[3:0] < brightness);

    always_comb begin
        seg_next = blank_digit ? SEG_BLANK : dec_seg;
        dig_next = '0;
        dig_next[scan_idx] = lit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_out    <= '0;
            dp_out     <= 1'b0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_next;
            dp_out     <= cur_dp;
            dig_en     <= dig_next;
            frame_done <= swap_point;
        end
    end

endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Testbench for seg7_digit_scanner: frame-level reference model
// with directed steps and randomized traffic.
module tb_seg7_digit_scanner;

    localparam int N     = 4;
    localparam int SLOT  = 32;
    localparam int BLANK = 4;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        digits_valid = 1'b0;
    logic        digits_ready;
    logic [3:0]  brightness = 4'hF;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  dig_en;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_digit_scanner #(
        .NUM_DIGITS   (N),
        .SLOT_CYCLES  (16'd32),
        .BLANK_CYCLES (16'd4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .digits_in    (digits_in),
        .dp_in        (dp_in),
        .digits_valid (digits_valid),
        .digits_ready (digits_ready),
        .brightness   (brightness),
        .lz_blank     (lz_blank),
        .seg_out      (seg_out),
        .dp_out       (dp_out),
        .dig_en       (dig_en),
        .frame_done   (frame_done)
    );

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int checks = 0;
    int errors = 0;

    // Reference model: time since reset plus displayed/pending frames
    int          n = 0;
    int          last_pos = -1;
    logic [15:0] m_active = '0;
    logic [15:0] m_shadow = '0;
    logic [3:0]  m_adp = '0;
    logic [3:0]  m_sdp = '0;
    bit          m_full = 0;
    bit          accepted = 0;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_dig;
    logic        e_fd;
    int          lit_cycles = 0;
    int          lit0_cycles = 0;

    function automatic logic [6:0] exp_seg(int idx);
        logic [3:0] d;
        d = 4'(m_active >> (4 * idx));
        if (d > 4'd9) return 7'h00;
        if (lz_blank && idx > 0 && (m_active >> (4 * idx)) == 16'd0)
            return 7'h00;
        return seg_tab[d];
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int  pos, slot, idx;
        bit  acc;
        @(posedge clk);
        accepted = 0;
        if (reset) begin
            n = 0; last_pos = -1;
            m_full = 0; m_active = '0; m_shadow = '0;
            m_adp = '0; m_sdp = '0;
            e_seg = '0; e_dp = 0; e_dig = '0; e_fd = 0;
        end else begin
            pos  = n % FRAME;
            slot = pos % SLOT;
            idx  = pos / SLOT;
            last_pos = pos;
            e_seg = exp_seg(idx);
            e_dp  = m_adp[idx];
            e_dig = (slot >= BLANK && (brightness == 4'hF || (slot % 16) < brightness))
                    ? 4'(1 << idx) : 4'd0;
            e_fd  = (pos == FRAME - 1);
            acc = digits_valid && !m_full;
            if (pos == FRAME - 1 && m_full) begin
                m_active = m_shadow; m_adp = m_sdp; m_full = 0;
            end
            if (acc) begin
                m_shadow = digits_in; m_sdp = dp_in; m_full = 1; accepted = 1;
            end
            n++;
        end
        #1;
        chk("seg_out", 16'(seg_out), 16'(e_seg));
        chk("dp_out", 16'(dp_out), 16'(e_dp));
        chk("dig_en", 16'(dig_en), 16'(e_dig));
        chk("frame_done", 16'(frame_done), 16'(e_fd));
        chk("digits_ready", 16'(digits_ready), 16'(!m_full));
        lit_cycles  += (dig_en != 4'd0) ? 1 : 0;
        lit0_cycles += dig_en[0] ? 1 : 0;
    endtask

    task automatic run(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic run_until(int p);
        int k = 0;
        do begin step(); k++; end while (last_pos != p && k < 2 * FRAME);
        chk("run_until_reached", 16'(last_pos), 16'(p));
    endtask

    task automatic offer(logic [15:0] d, logic [3:0] dp);
        int k = 0;
        digits_in = d; dp_in = dp; digits_valid = 1'b1;
        do begin step(); k++; end while (!accepted && k < 3 * FRAME);
        digits_valid = 1'b0;
        chk("offer_accepted", 16'(accepted), 16'd1);
    endtask

    initial begin
        // 1: reset, default display
        run(3);
        chk("reset_seg", 16'(seg_out), 16'h0);
        chk("reset_ready", 16'(digits_ready), 16'h1);
        reset = 1'b0;
        run(20);
        lit_cycles = 0; lit0_cycles = 0;
        run(FRAME);
        chk("lit_per_frame_b15", 16'(lit_cycles), 16'd112);
        chk("lit_digit0_b15", 16'(lit0_cycles), 16'd28);

        // 2: load 1234 with dp on digit 2
        offer(16'h1234, 4'b0100);
        step();
        chk("ready_low_after_load", 16'(digits_ready), 16'h0);
        run_until(FRAME - 1);
        run_until(10);
        chk("digit0_1234", 16'(seg_out), 16'h66);
        run_until(2 * SLOT + 10);
        chk("digit2_dp", 16'(dp_out), 16'h1);

        // 3: leading zero blanking
        lz_blank = 1'b1;
        offer(16'h0070, 4'b0000);
        run_until(FRAME - 1);
        run_until(3 * SLOT + 10);
        chk("lz_digit3", 16'(seg_out), 16'h0);
        run_until(1 * SLOT + 10);
        chk("lz_digit1", 16'(seg_out), 16'h07);
        lz_blank = 1'b0;
        run_until(2 * SLOT + 10);
        chk("nolz_digit2", 16'(seg_out), 16'h3F);

        // 4: brightness sweep, with mid-slot changes
        brightness = 4'd0;
        lit_cycles = 0;
        run(FRAME);
        chk("lit_per_frame_b0", 16'(lit_cycles), 16'd0);
        brightness = 4'd4;
        lit_cycles = 0;
        run(FRAME);
        chk("lit_per_frame_b4", 16'(lit_cycles), 16'd16);
        run(7);
        brightness = 4'd15;
        run(5);
        brightness = 4'd9;
        run(40);
        brightness = 4'hF;

        // 5: back-to-back offers and swap-point accept
        offer(16'h1111, 4'b0001);
        offer(16'h2222, 4'b0010);
        run_until(FRAME - 1);
        run_until(10);
        chk("b2b_digit0_2222", 16'(seg_out), 16'h5B);
        while ((n % FRAME) != FRAME - 1) step();
        offer(16'h0985, 4'b1000);
        run_until(10);
        chk("swap_accept_not_yet", 16'(seg_out), 16'h5B);
        run_until(FRAME - 1);
        run_until(10);
        chk("swap_accept_shown", 16'(seg_out), 16'h6D);

        // 6: non-BCD digit and reset with pending shadow data
        offer(16'h00B0, 4'b0010);
        run_until(FRAME - 1);
        run_until(SLOT + 10);
        chk("digit_b_blank", 16'(seg_out), 16'h0);
        chk("digit_b_dp", 16'(dp_out), 16'h1);
        run(5);
        offer(16'h8888, 4'b1111);
        run(3);
        reset = 1'b1;
        step();
        chk("rst_dig_en", 16'(dig_en), 16'h0);
        chk("rst_ready", 16'(digits_ready), 16'h1);
        reset = 1'b0;
        run(FRAME + 2);
        run_until(10);
        chk("shadow_lost", 16'(seg_out), 16'h3F);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 39) == 0) lz_blank = ~lz_blank;
            digits_valid = ($urandom_range(0, 29) == 0);
            digits_in = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
                        {4'($urandom_range(0, 9)) & {4{$urandom_range(0, 1) == 1}},
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9))};
            dp_in = 4'($urandom);
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            step();
            reset = 1'b0;
        end
        digits_valid = 1'b0;
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
